ysyx_23060236_lsu_read: RTL

YSYX_23060236_LSU_READ -- requirements
Module: ysyx_23060236_lsu_read

---
 rtl/ysyx_23060236_lsu_read.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060236_lsu_read.sv
// rtl/ysyx_23060236_lsu_read.sv - single-outstanding AXI-lite load unit with alignment, extension and timeout
module ysyx_23060236_lsu_read #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        drain_q, drain_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [1:0]  resp_err_q, resp_err_d;

  logic        misaligned;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;

  assign req_ready  = (state_q == IDLE) && !drain_q;
  // After a timeout the late beat is still owed to us; keep accepting it.
  assign rready     = (state_q == R) || drain_q;
  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

  assign misaligned = (req_size == 2'd3) ||
                      ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

  always_comb begin
    byte_v = 8'h00;
    case (off_q)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = off_q[1] ? rdata[31:16] : rdata[15:0];
    case (size_q)
      2'd0:    load_data = {{24{signed_q & byte_v[7]}}, byte_v};
      2'd1:    load_data = {{16{signed_q & half_v[15]}}, half_v};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    signed_d     = signed_q;
    drain_d      = drain_q;
    cnt_d        = cnt_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    if (drain_q && rvalid) drain_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          off_d    = req_addr[1:0];
          size_d   = req_size;
          signed_d = req_signed;
          if (misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 2'b11;
            resp_data_d  = 32'h0;
          end else begin
            state_d   = AR;
            araddr_d  = {req_addr[31:2], 2'b00};
            arvalid_d = 1'b1;
          end
        end
      end
      AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          cnt_d     = 16'h0;
          state_d   = R;
        end
      end
      R: begin
        if (rvalid) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          if (rresp != 2'b00) begin
            resp_err_d  = 2'b01;
            resp_data_d = 32'h0;
          end else begin
            resp_err_d  = 2'b00;
            resp_data_d = load_data;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 2'b10;
          resp_data_d  = 32'h0;
          drain_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      drain_q      <= 1'b0;
      cnt_q        <= 16'h0;
      araddr_q     <= 32'h0;
      arvalid_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      drain_q      <= drain_d;
      cnt_q        <= cnt_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule
